// File: rtl/program_ram_loader.sv
// Single-port program RAM with a boot loader: clears all words, assembles a
// byte stream MSB-first into words from address 0, then serves the CPU port.
module program_ram_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  write_en,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  busy,
   input  logic                  load_start,
   input  logic [7:0]            ld_data,
   input  logic                  ld_valid,
   input  logic                  ld_last,
   output logic                  ld_ready,
   output logic                  load_done,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int BPW   = (DATA_WIDTH + 7) / 8;
   localparam int SW    = BPW * 8;
   localparam int IW    = (BPW > 1) ? $clog2(BPW) : 1;

   // Handshake: a load byte transfers on a rising edge where ld_valid && ld_ready.
   typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [IW-1:0]         byte_idx;
   logic [SW-1:0]         sr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  accept;
   logic                  overflow;
   logic                  word_end;
   logic [SW-1:0]         sr_next;
   logic [SW-1:0]         word_full;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   assign accept   = (state == S_LOAD) && ld_valid && ld_ready;
   assign overflow = accept && (words_loaded == (ADDR_WIDTH+1)'(DEPTH));
   assign word_end = accept && !overflow && (ld_last || (byte_idx == IW'(BPW - 1)));
   assign sr_next  = SW'({sr, ld_data});
   // A word closed early by ld_last is left-aligned so its missing low bytes read as zero.
   assign word_full = sr_next << (8 * (BPW - 1 - int'(byte_idx)));

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = ptr;
      mem_wdata = '0;
      case (state)
         S_CLEAR: mem_we = 1'b1;
         S_LOAD: begin
            mem_we    = word_end && !load_start;
            mem_wdata = DATA_WIDTH'(word_full);
         end
         S_RUN: begin
            mem_we    = write_en;
            mem_waddr = addr;
            mem_wdata = din;
         end
         default: mem_we = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Read-first: a same-edge write to addr is not visible until the next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              dout <= '0;
      else if (state == S_RUN) dout <= mem[addr];
      else                     dout <= '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_CLEAR;
         ptr          <= '0;
         byte_idx     <= '0;
         sr           <= '0;
         busy         <= 1'b1;
         ld_ready     <= 1'b0;
         load_done    <= 1'b0;
         load_error   <= 1'b0;
         words_loaded <= '0;
      end else begin
         load_done <= 1'b0;
         if (load_start) begin
            state        <= S_CLEAR;
            ptr          <= '0;
            byte_idx     <= '0;
            sr           <= '0;
            busy         <= 1'b1;
            ld_ready     <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
         end else begin
            case (state)
               S_CLEAR: begin
                  ptr <= ptr + 1'b1;
                  if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                     state    <= S_LOAD;
                     ptr      <= '0;
                     byte_idx <= '0;
                     sr       <= '0;
                     ld_ready <= 1'b1;
                  end
               end
               S_LOAD: begin
                  if (accept) begin
                     if (overflow) begin
                        load_error <= 1'b1;
                        state      <= S_RUN;
                        busy       <= 1'b0;
                        ld_ready   <= 1'b0;
                        load_done  <= 1'b1;
                     end else begin
                        if (word_end) begin
                           ptr          <= ptr + 1'b1;
                           words_loaded <= words_loaded + 1'b1;
                           byte_idx     <= '0;
                           sr           <= '0;
                        end else begin
                           byte_idx <= byte_idx + 1'b1;
                           sr       <= sr_next;
                        end
                        if (ld_last) begin
                           state     <= S_RUN;
                           busy      <= 1'b0;
                           ld_ready  <= 1'b0;
                           load_done <= 1'b1;
                        end
                     end
                  end
               end
               S_RUN: ;
               default: state <= S_CLEAR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_ram_loader.sv
// Randomized bench for program_ram_loader; expected memory image is computed
// from the byte stream by word-chunking arithmetic.
module tb_program_ram_loader;

   localparam int AW    = 8;
   localparam int DW    = 12;
   localparam int DEPTH = 256;
   localparam int BPW   = 2;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] addr;
   logic [DW-1:0] din;
   logic          write_en;
   logic [DW-1:0] dout;
   logic          busy;
   logic          load_start;
   logic [7:0]    ld_data;
   logic          ld_valid;
   logic          ld_last;
   logic          ld_ready;
   logic          load_done;
   logic          load_error;
   logic [AW:0]   words_loaded;

   program_ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .write_en(write_en),
      .dout(dout), .busy(busy), .load_start(load_start), .ld_data(ld_data),
      .ld_valid(ld_valid), .ld_last(ld_last), .ld_ready(ld_ready),
      .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   logic [DW-1:0] model_mem [DEPTH];
   int          model_wl;
   int          model_err;
   logic [7:0]  stream [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
      model_wl  = 0;
      model_err = 0;
   endtask

   // Memory image after a fresh clear followed by loading the whole stream.
   task automatic model_load();
      int n, used, nw, idx;
      logic [31:0] w;
      model_clear();
      n    = stream.size();
      used = (n > DEPTH * BPW) ? DEPTH * BPW : n;
      nw   = (used + BPW - 1) / BPW;
      for (int k = 0; k < nw; k++) begin
         w = 0;
         for (int j = 0; j < BPW; j++) begin
            idx = k * BPW + j;
            w = (w << 8) | ((idx < used) ? 32'(stream[idx]) : 32'd0);
         end
         model_mem[k] = DW'(w);
      end
      model_wl  = nw;
      model_err = (n > DEPTH * BPW) ? 1 : 0;
   endtask

   task automatic wait_reset_clear();
      int cnt = 0;
      check("busy_in_clear", busy, 1);
      while (!ld_ready && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      check("reset_clear_cycles", cnt, 256);
      check("busy_in_load", busy, 1);
   endtask

   task automatic start_load();
      int cnt = 1;
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      check("start_busy", busy, 1);
      check("start_words_loaded", words_loaded, 0);
      check("start_load_error", load_error, 0);
      check("start_ld_ready", ld_ready, 0);
      while (!ld_ready && cnt < 400) begin
         @(negedge clk);
         cnt++;
      end
      check("clear_cycles", cnt, 257);
      model_clear();
   endtask

   // Offers the stream up to its terminating byte with random idle gaps and
   // random CPU traffic that must be ignored while the loader owns memory.
   task automatic do_load();
      int n, term;
      n    = stream.size();
      term = (n > DEPTH * BPW) ? DEPTH * BPW : n - 1;
      for (int i = 0; i <= term; i++) begin
         repeat ($urandom_range(0, 2)) begin
            ld_valid = 1'b0;
            ld_data  = 8'($urandom);
            ld_last  = 1'($urandom);
            write_en = 1'($urandom);
            addr     = AW'($urandom);
            din      = DW'($urandom);
            @(negedge clk);
         end
         check("ld_ready_offer", ld_ready, 1);
         check("dout_busy", dout, 0);
         ld_valid = 1'b1;
         ld_data  = stream[i];
         ld_last  = (i == n - 1);
         write_en = 1'b0;
         @(negedge clk);
         ld_valid = 1'b0;
         ld_last  = 1'b0;
         if (i < term) check("no_early_done", load_done, 0);
      end
      model_load();
      check("done_pulse", load_done, 1);
      check("busy_run", busy, 0);
      check("ld_ready_run", ld_ready, 0);
      check("words_loaded", words_loaded, model_wl);
      check("load_error", load_error, model_err);
      @(negedge clk);
      check("done_single", load_done, 0);
      check("words_loaded_hold", words_loaded, model_wl);
   endtask

   task automatic cpu_read(input int a, input string tag);
      addr     = AW'(a);
      write_en = 1'b0;
      @(negedge clk);
      check(tag, dout, model_mem[a]);
   endtask

   task automatic cpu_write(input int a, input logic [DW-1:0] d);
      addr     = AW'(a);
      din      = d;
      write_en = 1'b1;
      @(negedge clk);
      write_en = 1'b0;
      check("write_read_first", dout, model_mem[a]);
      model_mem[a] = d;
   endtask

   task automatic verify_image();
      int lim;
      lim = (model_wl + 2 > DEPTH) ? DEPTH : model_wl + 2;
      for (int k = 0; k < lim; k++) cpu_read(k, "image");
      repeat (3) cpu_read($urandom_range(0, DEPTH - 1), "image_rand");
   endtask

   initial begin
      rst_n = 1'b0; addr = '0; din = '0; write_en = 1'b0; load_start = 1'b0;
      ld_data = '0; ld_valid = 1'b0; ld_last = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1);
      check("rst_dout", dout, 0);
      check("rst_ld_ready", ld_ready, 0);
      check("rst_load_done", load_done, 0);
      check("rst_load_error", load_error, 0);
      check("rst_words_loaded", words_loaded, 0);
      rst_n = 1'b1;
      wait_reset_clear();

      // Three full words.
      stream = {8'h00, 8'hF9, 8'h00, 8'h90, 8'h09, 8'hF1};
      do_load();
      check("dir_w0", model_mem[0], 12'h0F9);
      check("dir_wl", words_loaded, 3);
      verify_image();

      // Final word closed early by ld_last.
      start_load();
      stream = {8'h0E, 8'h09, 8'h05};
      do_load();
      check("part_wl", words_loaded, 2);
      verify_image();
      check("part_m1_const", model_mem[1], 12'h500);

      // Read-first on a same-address write.
      cpu_write(5, 12'hABC);
      cpu_read(5, "after_write");

      // CPU writes during CLEAR must not land.
      write_en = 1'b1; addr = AW'(7); din = 12'h123;
      start_load();
      check("dout_clear", dout, 0);
      write_en = 1'b0;
      stream = {8'h01, 8'h02};
      do_load();
      cpu_read(7, "busy_write_ignored");
      cpu_read(5, "cleared_5");
      verify_image();

      // Overflow: more bytes than the memory holds.
      start_load();
      stream = {};
      for (int i = 0; i < DEPTH * BPW + 6; i++) stream.push_back(8'($urandom));
      do_load();
      check("ovf_error_sticky", load_error, 1);
      check("ovf_ready_low", ld_ready, 0);
      verify_image();

      // Restart mid-load after 3 words plus a partial byte.
      start_load();
      check("err_cleared", load_error, 0);
      for (int i = 0; i < 7; i++) begin
         ld_valid = 1'b1; ld_data = 8'($urandom); ld_last = 1'b0;
         @(negedge clk);
      end
      ld_valid = 1'b0;
      check("abort_wl", words_loaded, 3);
      start_load();
      stream = {8'h0A, 8'hBC};
      do_load();
      verify_image();

      // Random loads followed by random CPU traffic.
      for (int it = 0; it < 4; it++) begin
         start_load();
         stream = {};
         for (int i = 0; i < $urandom_range(1, 30); i++) stream.push_back(8'($urandom));
         do_load();
         verify_image();
         for (int op = 0; op < 20; op++) begin
            if ($urandom_range(0, 1) == 1) cpu_write($urandom_range(0, 40), DW'($urandom));
            else cpu_read($urandom_range(0, 40), "rand_read");
         end
      end

      // Asynchronous reset in the middle of a cycle.
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_busy", busy, 1);
      check("async_dout", dout, 0);
      check("async_wl", words_loaded, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      wait_reset_clear();
      stream = {8'hFF, 8'hFF, 8'h12};
      do_load();
      verify_image();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
